shared_reg_arbiter: RTL

Round-robin arbiter that time-shares a single W-bit asynchronously reset storage register between N requesters. Each requester raises `req`, waits for its one-hot `gnt`, and writes its `wdata` into the shared register on every cycle it holds both `req` and `gnt`. A hold limit bounds grant tenure so no requester can starve the others. The block sits in front of any shared configuration or data register that more than one upstream unit must update.

---
 rtl/shared_reg_arbiter_if.sv | 25 ++
 rtl/shared_reg_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/shared_reg_arbiter_if.sv
// Bundle between the requesters (master side) and the shared register arbiter (slave side).
interface shared_reg_arbiter_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
);
  localparam int unsigned OW = $clog2(N);

  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic           q_valid;
  logic [OW-1:0]  owner;
  logic           wr_strobe;

  modport master (
    output req, wdata,
    input  gnt, q, q_valid, owner, wr_strobe
  );

  modport slave (
    input  req, wdata,
    output gnt, q, q_valid, owner, wr_strobe
  );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter time-sharing one W-bit register between N requesters,
// with a bounded tenure of MAX_HOLD consecutive grant cycles.
module shared_reg_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned W        = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  shared_reg_arbiter_if.slave   bus
);

  localparam int unsigned PW = $clog2(N);
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          state, state_nx;
  logic [N-1:0]    gnt, gnt_nx;
  logic [PW-1:0]   hidx, hidx_nx;
  logic [PW-1:0]   ptr, ptr_nx;
  logic [HW-1:0]   hold_cnt, hold_nx;
  logic            wr_c;
  logic [W-1:0]    lane_c;

  logic [W-1:0]    q;
  logic            q_valid;
  logic [PW-1:0]   owner;
  logic            wr_strobe;

  // First requesting index at or after start, wrapping modulo N; MSB flags a hit.
  function automatic logic [PW:0] pick(input logic [PW-1:0] start, input logic [N-1:0] r);
    logic          found;
    logic [PW-1:0] idx;
    int unsigned   c;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      c = 32'(start) + k;
      if (c >= N) c = c - N;
      if (!found && r[PW'(c)]) begin
        found = 1'b1;
        idx   = PW'(c);
      end
    end
    return {found, idx};
  endfunction

  // Write data of the current holder.
  assign lane_c = bus.wdata[W*32'(hidx) +: W];

  // State, grant and tenure registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      gnt      <= '0;
      hidx     <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      hidx     <= hidx_nx;
      ptr      <= ptr_nx;
      hold_cnt <= hold_nx;
    end
  end

  // Next-state: arbitrate from idle, or continue / release / hand over the tenure.
  always_comb begin
    logic [PW:0]   win;
    logic [PW-1:0] rel_ptr;
    state_nx = state;
    gnt_nx   = gnt;
    hidx_nx  = hidx;
    ptr_nx   = ptr;
    hold_nx  = hold_cnt;
    wr_c     = 1'b0;
    win      = '0;
    rel_ptr  = '0;
    unique case (state)
      IDLE: begin
        win = pick(ptr, bus.req);
        if (win[PW]) begin
          state_nx = GRANT;
          hidx_nx  = win[PW-1:0];
          gnt_nx   = N'(1) << win[PW-1:0];
          hold_nx  = HW'(1);
        end
      end
      GRANT: begin
        wr_c = bus.req[hidx];
        if (bus.req[hidx] && (hold_cnt < HW'(MAX_HOLD))) begin
          hold_nx = hold_cnt + HW'(1);
        end else begin
          rel_ptr = (hidx == PW'(N - 1)) ? '0 : hidx + PW'(1);
          ptr_nx  = rel_ptr;
          win     = pick(rel_ptr, bus.req);
          if (win[PW]) begin
            hidx_nx = win[PW-1:0];
            gnt_nx  = N'(1) << win[PW-1:0];
            hold_nx = HW'(1);
          end else begin
            state_nx = IDLE;
            gnt_nx   = '0;
            hold_nx  = '0;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = '0;
        hold_nx  = '0;
      end
    endcase
  end

  // Shared register, ownership tracking and write strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q         <= '0;
      q_valid   <= 1'b0;
      owner     <= '0;
      wr_strobe <= 1'b0;
    end else begin
      wr_strobe <= wr_c;
      if (wr_c) begin
        q       <= lane_c;
        q_valid <= 1'b1;
        owner   <= hidx;
      end
    end
  end

  assign bus.gnt       = gnt;
  assign bus.q         = q;
  assign bus.q_valid   = q_valid;
  assign bus.owner     = owner;
  assign bus.wr_strobe = wr_strobe;

endmodule
